mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the CPU's single SRAM-like memory port between the instruction-fetch requester (physical PC from the MMU) and the data requester (MEM-stage load/store with byte strobes). It holds one outstanding transaction at a time, sequences the address and data handshakes, and returns read data with a one-cycle completion pulse. Both requesters stall the pipeline while their request is pending. It sits between the `mips` core and the bus bridge/cache.

## Interface

- `AW`, 32, address width
- `DW`, 32, data width (`DW/8` strobe bits)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `inst_req`  in  1  fetch request, held until `inst_done`
- `inst_addr`  in  AW  fetch physical address
- `inst_rdata`  out  DW  fetched word, valid when `inst_done`, held until next `inst_done`
- `inst_done`  out  1  one-cycle completion pulse
- `data_req`  in  1  data request, held until `data_done`
- `data_wr`  in  1  1 = store, 0 = load
- `data_wstrb`  in  DW/8  byte enables for stores
- `data_addr`  in  AW  data physical address
- `data_wdata`  in  DW  store data
- `data_rdata`  out  DW  load data, valid when `data_done`, held until next `data_done`
- `data_done`  out  1  one-cycle completion pulse
- `mem_req`  out  1  memory request
- `mem_wr`, `mem_wstrb`, `mem_addr`, `mem_wdata`  out  1/DW/8/AW/DW  memory request payload
- `mem_addr_ok`  in  1  request accepted this cycle (when `mem_req`=1)
- `mem_data_ok`  in  1  response valid this cycle
- `mem_rdata`  in  DW  response data
- `stall`  out  1  `(inst_req & ~inst_done) | (data_req & ~data_done)`, combinational

## Operation

- FSM states: IDLE, REQ, WAIT, DONE. One-bit `owner` (0 = inst, 1 = data), one-bit `last` (owner of the previous completed transaction).
- IDLE: with no request pending, remain. With one pending, grant it. With both pending, grant data unless `last`=1 (data), in which case grant inst; this alternates under continuous contention. On grant: latch the payload into internal regs (inst: `mem_wr`=0, `mem_wstrb`=0), set `owner`, go to REQ.
- REQ: `mem_req`=1 with latched payload. If `mem_addr_ok`=0, stay. If `mem_addr_ok`=1 and `mem_data_ok`=0, go to WAIT. If both are 1 in the same cycle, capture `mem_rdata` into the owner's rdata reg and go to DONE.
- WAIT: `mem_req`=0. On `mem_data_ok`=1, capture `mem_rdata` into the owner's rdata reg (stores capture too; the value is don't-care) and go to DONE.
- DONE: assert the owner's `*_done` for exactly this cycle, set `last`=`owner`, go to IDLE. Grant in IDLE occurs the next cycle, so a requester that still holds `req` in the DONE cycle is never re-issued the same transaction.
- Requester payload changes after grant are ignored; the latched copy is used.
- `mem_data_ok` in IDLE or DONE is ignored. `mem_data_ok` in REQ without `mem_addr_ok` is ignored.

## Timing

- Reset (`rst`=0, async): state IDLE, `owner`=0, `last`=0, `mem_req`=0, all payload regs 0, `inst_rdata`=`data_rdata`=0, both `done`=0. `stall` follows its inputs.
- Reset mid-transaction aborts it. No `done` is issued, and a late `mem_data_ok` lands in IDLE and is dropped.
- Minimum latency: `req` rises in cycle 0, REQ in cycle 1 (`mem_req`=1; `addr_ok` and `data_ok` both seen), `done` in cycle 2. With `addr_ok` in cycle 1 and `data_ok` in cycle 2, `done` is in cycle 3. Each extra wait cycle adds one.
- Back-to-back minimum is one transaction per 3 cycles (IDLE→REQ→DONE).
- `mem_req` and the payload are registered outputs, stable throughout REQ.

## Test plan

- Single fetch: `inst_req`=1, `inst_addr`=0x1FC00000; memory asserts `addr_ok` in cycle 1 and `data_ok` with 0x24080001 in cycle 2. Expected: `mem_addr`=0x1FC00000, `mem_wr`=0, `inst_done` pulses in cycle 3 only, `inst_rdata`=0x24080001, `stall` is 1 in cycles 0–2 and 0 in cycle 3.
- Simultaneous requests with fresh `last`=0: inst at 0x100 and a store of 0xDEADBEEF, strobe 0xF, to 0x200. Expected: data is served first (`mem_wr`=1, `mem_addr`=0x200, `mem_wstrb`=0xF), `data_done` pulses, then inst at 0x100 is served and `inst_done` pulses.
- Continuous contention, both reqs re-raised after each done for 4 transactions. Expected grant order: data, inst, data, inst.
- `addr_ok` and `data_ok` in the same cycle in REQ with `mem_rdata`=0x55AA55AA on a load. Expected: no WAIT cycle, `data_done` next cycle, `data_rdata`=0x55AA55AA.
- Backpressure: `addr_ok` held at 0 for 5 cycles while `inst_addr` toggles. Expected: `mem_req`=1 and `mem_addr` frozen at the granted value for all 5 cycles, completion follows normally.
- Reset in WAIT: `rst`=0 for one cycle, then `mem_data_ok`=1 two cycles later. Expected: all outputs 0 immediately, no `done` pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals shared by the arbiter and its neighbours.
// master = arbiter view, slave = core/memory-side view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              inst_req;
    logic [AW-1:0]     inst_addr;
    logic [DW-1:0]     inst_rdata;
    logic              inst_done;

    logic              data_req;
    logic              data_wr;
    logic [DW/8-1:0]   data_wstrb;
    logic [AW-1:0]     data_addr;
    logic [DW-1:0]     data_wdata;
    logic [DW-1:0]     data_rdata;
    logic              data_done;

    logic              mem_req;
    logic              mem_wr;
    logic [DW/8-1:0]   mem_wstrb;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DW-1:0]     mem_rdata;

    logic              stall;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_done,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_rdata, data_done,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output stall
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_done,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_rdata, data_done,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// one outstanding transaction at a time, with round-robin under contention.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.master   io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_mem_req;
    logic              r_mem_wr;
    logic [DW/8-1:0]   r_mem_wstrb;
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;
    logic [DW-1:0]     r_inst_rdata;
    logic [DW-1:0]     r_data_rdata;
    logic              r_inst_done;
    logic              r_data_done;

    logic              w_grant_data;
    logic              w_capture;

    // Data wins a tie unless it also won the previous transaction.
    assign w_grant_data = io_bus.data_req & (~io_bus.inst_req | ~r_last);

    assign w_capture = ((r_state == S_REQ) & io_bus.mem_addr_ok & io_bus.mem_data_ok) |
                       ((r_state == S_WAIT) & io_bus.mem_data_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_wstrb  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;

            // Done pulses are raised on entry to DONE so they line up with that state.
            if (w_capture) begin
                if (r_owner) r_data_rdata <= io_bus.mem_rdata;
                else         r_inst_rdata <= io_bus.mem_rdata;
                r_inst_done <= ~r_owner;
                r_data_done <= r_owner;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_data) begin
                        r_owner     <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= io_bus.data_wr;
                        r_mem_wstrb <= io_bus.data_wstrb;
                        r_mem_addr  <= io_bus.data_addr;
                        r_mem_wdata <= io_bus.data_wdata;
                        r_state     <= S_REQ;
                    end else if (io_bus.inst_req) begin
                        r_owner     <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_wstrb <= '0;
                        r_mem_addr  <= io_bus.inst_addr;
                        r_mem_wdata <= '0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (io_bus.mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= io_bus.mem_data_ok ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io_bus.mem_data_ok) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.mem_req    = r_mem_req;
    assign io_bus.mem_wr     = r_mem_wr;
    assign io_bus.mem_wstrb  = r_mem_wstrb;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;
    assign io_bus.inst_rdata = r_inst_rdata;
    assign io_bus.data_rdata = r_data_rdata;
    assign io_bus.inst_done  = r_inst_done;
    assign io_bus.data_done  = r_data_done;

    assign io_bus.stall = (io_bus.inst_req & ~r_inst_done) | (io_bus.data_req & ~r_data_done);
endmodule
